// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and sizing helper for the round-robin arbiter
package arbiter_pkg;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {IDLE, GRANT} arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick: first set candidate at or above ptr, wrapping
module rr_select
  import arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // The upper copy supplies the wrapped-around candidates below ptr.
  assign dbl = {cand, cand};

  always_comb begin
    masked = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && masked[i]) begin
        found  = 1'b1;
        winner = (i >= N) ? W'(i - N) : W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - locked round-robin arbiter; define ARB_TIMEOUT_EN for forced hand-over
// after MAX_HOLD_CYCLES when another requester is waiting.
module rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 4,
  parameter int MAX_HOLD_CYCLES = 16,
  localparam int ID_WIDTH       = id_width(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQUESTERS-1:0] req,
  output logic [NUM_REQUESTERS-1:0] gnt,
  output logic [ID_WIDTH-1:0]       gnt_id,
  output logic                      gnt_valid
);

  localparam int N = NUM_REQUESTERS;
  localparam int W = ID_WIDTH;

  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 64 || MAX_HOLD_CYCLES < 2) begin : g_bad_params
    $error("rr_arbiter: parameter out of range");
  end

  arb_state_t   state, state_n;
  logic [W-1:0] ptr, ptr_n;
  logic [N-1:0] gnt_n;
  logic [W-1:0] id_n;
  logic [N-1:0] cand;
  logic [W-1:0] winner;
  logic         found;
  logic         load;
  logic [W:0]   ptr_inc;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD_CYCLES) + 1;
  logic [HW-1:0] hold;
  logic          timeout;

  assign timeout = (hold == HW'(MAX_HOLD_CYCLES - 1)) && |(req & ~gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else if (load || state_n == IDLE) begin
      hold <= '0;
    end else if (state == GRANT && hold != HW'(MAX_HOLD_CYCLES - 1)) begin
      hold <= hold + 1'b1;
    end
  end
`endif

  // Only a pre-emption needs the owner masked; a released owner's bit is already clear.
  always_comb begin
    cand = req;
`ifdef ARB_TIMEOUT_EN
    if (state == GRANT && req[gnt_id] && timeout) cand = req & ~gnt;
`endif
  end

  rr_select #(.N(N), .W(W)) u_select (
    .cand   (cand),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  assign ptr_inc = {1'b0, winner} + 1'b1;

  always_comb begin
    load    = 1'b0;
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (found) load = 1'b1;
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          if (found) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout) load = 1'b1;
`endif
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
    if (load) begin
      state_n = GRANT;
      gnt_n   = N'(1) << winner;
      id_n    = winner;
      ptr_n   = (ptr_inc >= (W + 1)'(N)) ? '0 : ptr_inc[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_id    <= id_n;
      gnt_valid <= |gnt_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - checks rr_arbiter (N=4 and N=3 instances) against a behavioural model
module tb_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = '0;
  logic [2:0] req3 = '0;
  logic [3:0] gnt4;
  logic [1:0] gnt_id4;
  logic       gnt_valid4;
  logic [2:0] gnt3;
  logic [1:0] gnt_id3;
  logic       gnt_valid3;

  int total = 0;
  int bad   = 0;

  int o4 = -1, p4 = 0, h4 = 0, i4 = 0;
  int o3 = -1, p3 = 0, h3 = 0, i3 = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQUESTERS(4), .MAX_HOLD_CYCLES(MAXH)) u4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_id(gnt_id4), .gnt_valid(gnt_valid4)
  );

  rr_arbiter #(.NUM_REQUESTERS(3), .MAX_HOLD_CYCLES(MAXH)) u3 (
    .clk(clk), .rst(rst), .req(req3), .gnt(gnt3), .gnt_id(gnt_id3), .gnt_valid(gnt_valid3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Owner/pointer/held-cycles view of the arbiter, advanced once per clock edge.
  task automatic model_step(input int n, input logic [3:0] r, input bit rs,
                            inout int owner, inout int ptr, inout int held, inout int id);
    logic [3:0] c;
    int pick;
    if (rs) begin
      owner = -1; ptr = 0; held = 0; id = 0;
      return;
    end
    c = r;
    if (owner >= 0 && r[owner]) begin
      c = '0;
`ifdef ARB_TIMEOUT_EN
      if (held >= MAXH) begin
        c = r;
        c[owner] = 1'b0;
      end
`endif
      if (c == '0) begin
        held++;
        return;
      end
    end
    pick = -1;
    for (int k = 0; k < n; k++) begin
      if (pick < 0 && c[(ptr + k) % n]) pick = (ptr + k) % n;
    end
    if (pick < 0) begin
      owner = -1;
      held  = 0;
      return;
    end
    owner = pick;
    id    = pick;
    ptr   = (pick + 1) % n;
    held  = 1;
  endtask

  task automatic tick();
    model_step(4, req4, rst, o4, p4, h4, i4);
    model_step(3, {1'b0, req3}, rst, o3, p3, h3, i3);
    @(posedge clk);
    #1;
    chk("gnt4", 32'(gnt4), (o4 < 0) ? 32'd0 : (32'd1 << o4));
    chk("gnt_id4", 32'(gnt_id4), 32'(i4));
    chk("gnt_valid4", 32'(gnt_valid4), 32'(o4 >= 0));
    chk("gnt3", 32'(gnt3), (o3 < 0) ? 32'd0 : (32'd1 << o3));
    chk("gnt_id3", 32'(gnt_id3), 32'(i3));
    chk("gnt_valid3", 32'(gnt_valid3), 32'(o3 >= 0));
    chk("gnt_id3_range", 32'(gnt_id3 < 2'd3), 32'd1);
  endtask

  initial begin
    // reset, then idle
    rst = 1'b1; tick(); tick();
    chk("reset_gnt", 32'(gnt4), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("idle_valid", 32'(gnt_valid4), 32'd0);

    // single requester: 1-cycle latency, long hold, release to idle
    req4 = 4'b0100; tick();
    chk("single_gnt", 32'(gnt4), 32'h4);
    chk("single_id", 32'(gnt_id4), 32'd2);
    for (int k = 0; k < 10; k++) tick();
    chk("single_hold", 32'(gnt4), 32'h4);
    req4 = 4'b0000; tick();
    chk("release_idle", 32'(gnt4), 32'd0);

    // reset during an active grant
    req4 = 4'b1111; tick();
    chk("pre_reset_valid", 32'(gnt_valid4), 32'd1);
    rst = 1'b1; tick();
    chk("mid_reset_gnt", 32'(gnt4), 32'd0);
    rst = 1'b0;

    // all requesting, each owner releases for one cycle: 0,1,2,3,0,1 back to back
    req4 = 4'b1111; tick();
    for (int k = 0; k < 6; k++) begin
      chk("rotate_id", 32'(gnt_id4), 32'(k % 4));
      chk("rotate_valid", 32'(gnt_valid4), 32'd1);
      req4 = 4'b1111 & ~gnt4;
      tick();
    end

    // wrap-around from owner 1 to requester 0, then pointer sits at 1
    rst = 1'b1; req4 = 4'b0000; tick(); rst = 1'b0;
    req4 = 4'b0010; tick();
    chk("wrap_owner1", 32'(gnt_id4), 32'd1);
    req4 = 4'b0001; tick();
    chk("wrap_gnt0", 32'(gnt4), 32'h1);
    req4 = 4'b1110; tick();
    chk("wrap_ptr1", 32'(gnt_id4), 32'd1);

    // contention against a holding owner
    rst = 1'b1; req4 = 4'b0000; tick(); rst = 1'b0;
    req4 = 4'b0001; tick();
    chk("hold_first", 32'(gnt4), 32'h1);
    tick();
    req4 = 4'b1001;
`ifdef ARB_TIMEOUT_EN
    tick(); chk("to_hold3", 32'(gnt4), 32'h1);
    tick(); chk("to_hold4", 32'(gnt4), 32'h1);
    tick(); chk("to_preempt", 32'(gnt4), 32'h8);
    rst = 1'b1; req4 = 4'b0000; tick(); rst = 1'b0;
    req4 = 4'b0001;
    for (int k = 0; k < 22; k++) tick();
    chk("to_alone_hold", 32'(gnt4), 32'h1);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("locked_hold", 32'(gnt4), 32'h1);
`endif

    // non-power-of-two rotation on the N=3 instance
    rst = 1'b1; req4 = 4'b0000; tick(); rst = 1'b0;
    req3 = 3'b111; tick();
    for (int k = 0; k < 4; k++) begin
      chk("n3_rotate_id", 32'(gnt_id3), 32'(k % 3));
      req3 = 3'b111 & ~gnt3;
      tick();
    end

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) req4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) req3 = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_REQUESTERS requesters using a req/gnt handshake.
- A grant is locked: it is held until the owner releases its request.
- The search for the next owner starts one index above the previous owner, so no requester starves.
- Sits in front of shared datapaths (bus, memory port, encoder-fed resource); the gnt_id output drives the shared resource's select mux directly.

Parameters:
- NUM_REQUESTERS, 4, number of requesters; legal range 2..64.
- MAX_HOLD_CYCLES, 16, maximum grant length in cycles when ARB_TIMEOUT_EN is defined; must be >= 2; ignored otherwise.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  NUM_REQUESTERS  request vector; bit i belongs to requester i
- gnt  output  NUM_REQUESTERS  one-hot grant, registered
- gnt_id  output  ID_WIDTH  binary index of the owner, registered; ID_WIDTH = $clog2(NUM_REQUESTERS)
- gnt_valid  output  1  high while any grant is active; equals |gnt

Behaviour:
- Reset: synchronous, active-high, one clock, single clock domain.
  - Outputs: gnt='0, gnt_id='0, gnt_valid=0.
  - Internal: state=IDLE, pointer=0, hold counter=0.
  - Reset asserted mid-grant drops gnt on the next edge; pending req is ignored while rst=1.
- Selection function, combinational: starting at index pointer, scan upward with wrap-around (pointer, pointer+1, ..., N-1, 0, ..., pointer-1); the first set bit of the candidate vector wins. "No candidate" is a distinct result.
- IDLE state:
  - If |req: next edge goes to GRANT with owner = selection(req), gnt=onehot(owner), gnt_id=owner, gnt_valid=1, pointer = (owner+1) mod N.
  - Otherwise stay in IDLE.
  - Latency from req rising to gnt: exactly 1 cycle.
- GRANT state, owner holds while req[owner]=1.
- GRANT state, req[owner]=0 (release):
  - The same edge re-arbitrates over req; there is no dead cycle between owners.
  - If another request is set, grant it and update pointer.
  - Else go to IDLE and clear gnt.
- Grant updates: gnt, gnt_id and gnt_valid change only on clock edges and never glitch between edges.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id is held at its last value when gnt_valid=0.
- Requester dropping req while not granted: legal, no effect.
- Requester re-raising req in the cycle after its release: competes normally; the advanced pointer gives it lowest priority.
- All requests asserted continuously with single-cycle holds: grants rotate 0,1,2,...,N-1,0.
- Wrap-around: pointer is modulo NUM_REQUESTERS, which need not be a power of two. Arithmetic is done at ID_WIDTH+1 bits, then compared against N.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter (width $clog2(MAX_HOLD_CYCLES)+1) clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD_CYCLES-1 and any req other than the owner is set, the next edge forcibly moves the grant. The selection runs over req with the owner's bit masked, and pointer advances.
  - If no other request is pending, the owner keeps the grant and the counter saturates.
  - The pre-empted requester must tolerate losing gnt while req is still high.
- Undefined: no counter is instantiated; grants are held indefinitely while req[owner]=1.

Decomposition:
- Package arbiter_pkg:
  - function id_width(n) returning $clog2(n), with a minimum of 1.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
- One sub-module, rr_select: purely combinational.
  - Inputs: candidate vector and pointer.
  - Outputs: winner index and found flag.
  - Implementation: a double-width masked scan.
- rr_arbiter holds the FSM, pointer, registered outputs and the optional counter.

Test Plan:
- N=4: reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0. Apply rst=1 during an active grant -> gnt=0 on next edge.
- req=4'b0100 at cycle 0 -> cycle 1: gnt=4'b0100, gnt_id=2. Hold 10 cycles; drop req[2] -> gnt=0, state IDLE on next edge.
- req=4'b1111 held, each owner drops req for exactly one cycle on grant, then re-raises -> grant order 0,1,2,3,0,1 with no idle cycle between owners.
- Owner 1 granted (pointer=2); req=4'b0011 with req[1] released -> next grant to 0 (wrap-around), pointer becomes 1.
- N=3 (non-power-of-two), req=3'b111 rotating -> order 0,1,2,0; gnt_id never reaches 3.
- ARB_TIMEOUT_EN, MAX_HOLD_CYCLES=4: requester 0 holds req, requester 3 requests at cycle 2 -> gnt moves to 3 after requester 0 has held for 4 cycles. Alone, requester 0 keeps the grant for 20+ cycles.
